divider_checker: RTL and testbench



---
 rtl/divchk_pkg.sv | 27 ++
 rtl/divchk_shift_mult.sv | 78 +++++++
 rtl/divider_checker.sv | 193 +++++++++++++++++++
 tb/tb_divider_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/divchk_pkg.sv
// ============================================================================
// Module   : divchk_pkg
// Purpose  : Shared types, counter constants and timer sizing for the
//            divider result checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package divchk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MULT = 2'd2,
    CMP  = 2'd3
  } state_e;

  localparam int             CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  function automatic int timer_width(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

`default_nettype wire

// File: rtl/divchk_shift_mult.sv
// ============================================================================
// Module   : divchk_shift_mult
// Purpose  : WIDTH-cycle shift-add multiplier; one multiplier bit per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module divchk_shift_mult
  import divchk_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               active_q, active_d;

  // done flags the edge that performs the final partial-product step
  assign done    = active_q && (cnt_q == CNT_LAST);
  assign product = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, b};
      mplier_d = a;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/divider_checker.sv
// ============================================================================
// Module   : divider_checker
// Purpose  : Result monitor for the sequential divider: captures a job,
//            verifies Q*B+R==A and R<B, keeps saturating pass/fail counts.
//            DIVCHK_DIV0_EN: B=0 passes iff Q is all ones and R==A.
// Revision : 1.0
// ============================================================================
`default_nettype none

module divider_checker
  import divchk_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             done,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             check_valid,
  output logic             check_pass,
  output logic             timeout,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam int               TMR_W    = timer_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               to_q, to_d;
  logic               valid_q, valid_d, pass_q, pass_d, tout_q, tout_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
`ifdef DIVCHK_DIV0_EN
  logic [WIDTH-1:0]   q_q, q_d;
`endif

  logic               mult_start, mult_done;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH:0]   sum;
  logic               b_zero, mul_ok, div0_ok, verdict;

  assign b_zero     = (b_q == '0);
  assign mult_start = (state_q == WAIT) && done && !b_zero;

  divchk_shift_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mult_start),
    .a       (Q),
    .b       (b_q),
    .done    (mult_done),
    .product (product)
  );

  // Verdict is evaluated from registered job data while in CMP
  always_comb begin
    sum     = {1'b0, product} + {{(WIDTH+1){1'b0}}, r_q};
    mul_ok  = (sum == {{(WIDTH+1){1'b0}}, a_q}) && (r_q < b_q);
`ifdef DIVCHK_DIV0_EN
    div0_ok = (q_q == {WIDTH{1'b1}}) && (r_q == a_q);
`else
    div0_ok = 1'b0;
`endif
    verdict = !to_q && (b_zero ? div0_ok : mul_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = WAIT;
      WAIT: begin
        if (done) begin
          state_d = b_zero ? CMP : MULT;
        end else if (timer_q == TMR_LAST) begin
          state_d = CMP;
        end
      end
      MULT: if (mult_done) state_d = CMP;
      CMP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
`ifdef DIVCHK_DIV0_EN
    q_d        = q_q;
`endif
    timer_d    = timer_q;
    to_d       = to_q;
    valid_d    = 1'b0;
    pass_d     = 1'b0;
    tout_d     = 1'b0;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          timer_d = '0;
          to_d    = 1'b0;
        end
      end
      WAIT: begin
        if (done) begin
          r_d = R;
`ifdef DIVCHK_DIV0_EN
          q_d = Q;
`endif
        end else if (timer_q == TMR_LAST) begin
          to_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CMP: begin
        valid_d = 1'b1;
        pass_d  = verdict;
        tout_d  = to_q;
        if (verdict) begin
          if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
        end else begin
          if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
`ifdef DIVCHK_DIV0_EN
      q_q        <= '0;
`endif
      timer_q    <= '0;
      to_q       <= 1'b0;
      valid_q    <= 1'b0;
      pass_q     <= 1'b0;
      tout_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
`ifdef DIVCHK_DIV0_EN
      q_q        <= q_d;
`endif
      timer_q    <= timer_d;
      to_q       <= to_d;
      valid_q    <= valid_d;
      pass_q     <= pass_d;
      tout_q     <= tout_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign check_valid = valid_q;
  assign check_pass  = pass_q;
  assign timeout     = tout_q;
  assign pass_count  = pass_cnt_q;
  assign fail_count  = fail_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_divider_checker.sv
// ============================================================================
// Module   : tb_divider_checker
// Purpose  : Self-checking bench for divider_checker: directed vector table,
//            hand-written corner sequences and randomized jobs vs. a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_divider_checker;

  localparam int WIDTH   = 24;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0, B = '0, Q = '0, R = '0;
  logic             done = 1'b0;
  logic             busy, check_valid, check_pass, timeout;
  logic [15:0]      pass_count, fail_count;

  int checks = 0;
  int errors = 0;
  int exp_pc = 0;
  int exp_fc = 0;

  divider_checker #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A           (A),
    .B           (B),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .check_valid (check_valid),
    .check_pass  (check_pass),
    .timeout     (timeout),
    .pass_count  (pass_count),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a, b, q, r;
    int               delay;
    bit               give_done;
    int               extra;      // 0 plain, 1 done alongside start, 2 start repeated in WAIT
    bit               exp_pass;
    bit               exp_to;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference verdict straight from the division identity
  function automatic bit model_pass(input logic [WIDTH-1:0] a, b, q, r);
    longint unsigned la, lb, lq, lr;
    la = 64'(a); lb = 64'(b); lq = 64'(q); lr = 64'(r);
    if (lb == 0) begin
`ifdef DIVCHK_DIV0_EN
      return (q == {WIDTH{1'b1}}) && (r == a);
`else
      return 1'b0;
`endif
    end
    return (lq * lb + lr == la) && (lr < lb);
  endfunction

  task automatic run_job(input vec_t v, input string tag);
    int  k;
    int  exp_lat;
    bit  seen;
    start = 1'b1; A = v.a; B = v.b;
    if (v.extra == 1) begin done = 1'b1; Q = '0; R = '0; end
    @(negedge clk);
    start = 1'b0; done = 1'b0;
    A = 24'($urandom); B = 24'($urandom);
    chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
    if (v.give_done) begin
      for (int i = 0; i < v.delay; i++) begin
        if (v.extra == 2 && i == 0) begin start = 1'b1; A = v.a + 24'd1; B = v.b; end
        @(negedge clk);
        start = 1'b0;
      end
      done = 1'b1; Q = v.q; R = v.r;
      @(negedge clk);
      done = 1'b0; Q = 24'($urandom); R = 24'($urandom);
      exp_lat = (v.b == '0) ? 1 : WIDTH + 1;
    end else begin
      exp_lat = TIMEOUT + 1;
    end
    seen = 1'b0;
    k = 0;
    while (!seen && k < exp_lat + 20) begin
      if (check_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (v.exp_pass) begin if (exp_pc < 65535) exp_pc++; end
    else begin if (exp_fc < 65535) exp_fc++; end
    chk({tag, " valid_seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(k), 64'(exp_lat));
    if (seen) begin
      chk({tag, " check_pass"}, 64'(check_pass), 64'(v.exp_pass));
      chk({tag, " timeout"}, 64'(timeout), 64'(v.exp_to));
      chk({tag, " busy_at_verdict"}, 64'(busy), 64'd0);
      chk({tag, " pass_count"}, 64'(pass_count), 64'(exp_pc));
      chk({tag, " fail_count"}, 64'(fail_count), 64'(exp_fc));
      @(negedge clk);
      chk({tag, " valid_one_cycle"}, 64'(check_valid), 64'd0);
    end
  endtask

  task automatic watch_quiet(input int cycles, input string tag);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (check_valid || busy) hits++;
    end
    chk({tag, " quiet_cycles"}, 64'(hits), 64'd0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{24'h2625A0, 24'h001068, 24'd595, 24'd1000, 3, 1'b1, 0, 1'b1, 1'b0};
    tbl[1] = '{24'h2625A0, 24'h001068, 24'd595, 24'd1001, 2, 1'b1, 0, 1'b0, 1'b0};
    tbl[2] = '{24'd10,     24'd3,      24'd2,   24'd4,    1, 1'b1, 0, 1'b0, 1'b0};
    tbl[3] = '{24'd100,    24'd7,      24'd0,   24'd0,    0, 1'b0, 0, 1'b0, 1'b1};
`ifdef DIVCHK_DIV0_EN
    tbl[4] = '{24'd5,      24'd0,      24'hFFFFFF, 24'd5, 4, 1'b1, 0, 1'b1, 1'b0};
`else
    tbl[4] = '{24'd5,      24'd0,      24'hFFFFFF, 24'd5, 4, 1'b1, 0, 1'b0, 1'b0};
`endif
    // done on the very cycle the timer expires still counts as a normal job
    tbl[5] = '{24'd100,    24'd7,      24'd14,  24'd2, TIMEOUT - 1, 1'b1, 0, 1'b1, 1'b0};
    tbl[6] = '{24'd255,    24'd16,     24'd15,  24'd15,   0, 1'b1, 1, 1'b1, 1'b0};
    tbl[7] = '{24'd10,     24'd3,      24'd3,   24'd1,    2, 1'b1, 2, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset check_valid", 64'(check_valid), 64'd0);
    chk("reset check_pass", 64'(check_pass), 64'd0);
    chk("reset timeout", 64'(timeout), 64'd0);
    chk("reset pass_count", 64'(pass_count), 64'd0);
    chk("reset fail_count", 64'(fail_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i], $sformatf("vec%0d", i));
      if (i == 3) begin
        done = 1'b1; Q = 24'd14; R = 24'd2;
        @(negedge clk);
        done = 1'b0;
        watch_quiet(30, "done_in_idle");
      end
    end

    // Abort a job mid-multiply
    start = 1'b1; A = 24'h2625A0; B = 24'h001068;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    done = 1'b1; Q = 24'd595; R = 24'd1000;
    @(negedge clk);
    done = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset pass_count", 64'(pass_count), 64'd0);
    chk("midreset fail_count", 64'(fail_count), 64'd0);
    exp_pc = 0;
    exp_fc = 0;
    @(negedge clk);
    reset = 1'b0;
    watch_quiet(40, "after_midreset");
    run_job(tbl[0], "post_reset");

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      int   mode;
      v.a = 24'($urandom);
      v.b = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom_range(1, 32'hFFFFFF) >> $urandom_range(0, 20));
      if (v.b == 24'd0) v.b = ($urandom_range(0, 1) == 0) ? 24'd0 : 24'd1;
      if (v.b == '0) begin
        v.q = '1; v.r = v.a;
      end else begin
        v.q = v.a / v.b; v.r = v.a % v.b;
      end
      mode = $urandom_range(0, 4);
      case (mode)
        1: v.r = v.r + 24'd1;
        2: v.q = v.q + 24'd1;
        3: if (v.b != '0 && v.q != '0) begin v.q = v.q - 24'd1; v.r = v.r + v.b; end
        default: ;
      endcase
      v.delay     = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 10);
      v.give_done = 1'b1;
      v.extra     = $urandom_range(0, 2);
      if (v.extra == 2 && v.delay == 0) v.delay = 1;
      v.exp_pass  = model_pass(v.a, v.b, v.q, v.r);
      v.exp_to    = 1'b0;
      run_job(v, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
